// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the pipeline-side fetch and load/store handshakes, the shared
// memory port and the access counters of mem_access_ctrl.
//   fetch  : if_req/if_pc in, if_valid/if_instr/if_fault/if_stall out
//   data   : dm_req/dm_we/dm_addr/dm_wdata/dm_funct3 in,
//            dm_done/dm_rdata/dm_fault/dm_stall out
//   memory : mem_clk_slow/mem_read/mem_write/mem_addr/mem_wdata/mem_funct3
//            out, mem_inst_out/mem_data_out in
//   stats  : fetch_cnt/load_cnt/store_cnt/fault_cnt out
// Modports: slave = the controller, master = pipeline plus memory around it.
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
);
    logic              if_req;
    logic [31:0]       if_pc;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic              if_fault;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [31:0]       dm_addr;
    logic [31:0]       dm_wdata;
    logic [2:0]        dm_funct3;
    logic              dm_done;
    logic [31:0]       dm_rdata;
    logic              dm_fault;
    logic              dm_stall;

    logic              mem_clk_slow;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_inst_out;
    logic [31:0]       mem_data_out;

    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
    logic [CNT_W-1:0]  fault_cnt;

    modport slave (
        input  if_req, if_pc, dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
               mem_inst_out, mem_data_out,
        output if_valid, if_instr, if_fault, if_stall,
               dm_done, dm_rdata, dm_fault, dm_stall,
               mem_clk_slow, mem_read, mem_write, mem_addr, mem_wdata, mem_funct3,
               fetch_cnt, load_cnt, store_cnt, fault_cnt
    );

    modport master (
        output if_req, if_pc, dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
               mem_inst_out, mem_data_out,
        input  if_valid, if_instr, if_fault, if_stall,
               dm_done, dm_rdata, dm_fault, dm_stall,
               mem_clk_slow, mem_read, mem_write, mem_addr, mem_wdata, mem_funct3,
               fetch_cnt, load_cnt, store_cnt, fault_cnt
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Single-port initiator for the 512-byte unified instruction/data memory.
// A free-running phase register alternates FETCH and DATA cycles; the memory
// port is steered combinationally by the current phase and the results are
// registered back to the pipeline as one-cycle valid/done pulses. Illegal
// alignment, range or funct3 are caught here so the memory never sees a
// strobe for them. Four saturating counters track activity.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   bus  - mem_access_ctrl_if.slave (fetch, data, memory and counter signals)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   bus
);

    typedef enum logic {FETCH = 1'b0, DATA = 1'b1} phase_t;

    localparam logic [31:0] NOP      = 32'h0000_0033;
    // Highest legal fetch pc is the last aligned word below the top.
    localparam logic [31:0] PC_LIMIT = (32'd1 << ADDR_W) - 32'd3;
    localparam logic [32:0] MEM_SIZE = 33'd1 << ADDR_W;

    phase_t            phase_reg, phase_next;

    logic              if_valid_reg, if_fault_reg;
    logic [31:0]       if_instr_reg;
    logic              dm_done_reg, dm_fault_reg;
    logic [31:0]       dm_rdata_reg;
    logic [CNT_W-1:0]  fetch_cnt_reg, load_cnt_reg, store_cnt_reg, fault_cnt_reg;

    logic              if_bad;
    logic              dm_bad;
    logic [32:0]       dm_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign if_bad = (bus.if_pc[1:0] != 2'b00) || (bus.if_pc >= PC_LIMIT);

    // Data legality: funct3 set depends on direction, alignment on size, and
    // the last byte touched must stay inside the memory.
    always_comb begin
        dm_bad  = 1'b0;
        dm_last = {1'b0, bus.dm_addr};
        case (bus.dm_funct3[1:0])
            2'b01:   dm_last = {1'b0, bus.dm_addr} + 33'd1;
            2'b10:   dm_last = {1'b0, bus.dm_addr} + 33'd3;
            default: dm_last = {1'b0, bus.dm_addr};
        endcase
        if (bus.dm_we) begin
            if (bus.dm_funct3[2] || (bus.dm_funct3[1:0] == 2'b11))
                dm_bad = 1'b1;
        end else begin
            if ((bus.dm_funct3 == 3'b011) || (bus.dm_funct3[2:1] == 2'b11))
                dm_bad = 1'b1;
        end
        if ((bus.dm_funct3[1:0] == 2'b01) && bus.dm_addr[0])
            dm_bad = 1'b1;
        if ((bus.dm_funct3[1:0] == 2'b10) && (bus.dm_addr[1:0] != 2'b00))
            dm_bad = 1'b1;
        if (dm_last >= MEM_SIZE)
            dm_bad = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            phase_reg <= FETCH;
        else
            phase_reg <= phase_next;
    end

    // Next phase and memory-port steering.
    always_comb begin
        phase_next       = (phase_reg == FETCH) ? DATA : FETCH;
        bus.mem_clk_slow = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_funct3   = '0;
        if (phase_reg == FETCH) begin
            bus.mem_clk_slow = 1'b1;
            bus.mem_addr     = bus.if_pc[ADDR_W-1:0];
        end else begin
            bus.mem_addr   = bus.dm_addr[ADDR_W-1:0];
            bus.mem_wdata  = bus.dm_wdata;
            bus.mem_funct3 = bus.dm_funct3;
            if (bus.dm_req && !dm_bad) begin
                bus.mem_read  = !bus.dm_we;
                bus.mem_write = bus.dm_we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid_reg  <= 1'b0;
            if_fault_reg  <= 1'b0;
            if_instr_reg  <= NOP;
            dm_done_reg   <= 1'b0;
            dm_fault_reg  <= 1'b0;
            dm_rdata_reg  <= '0;
            fetch_cnt_reg <= '0;
            load_cnt_reg  <= '0;
            store_cnt_reg <= '0;
            fault_cnt_reg <= '0;
        end else begin
            // Pulses last one cycle unless re-armed below.
            if_valid_reg <= 1'b0;
            if_fault_reg <= 1'b0;
            dm_done_reg  <= 1'b0;
            dm_fault_reg <= 1'b0;
            if (phase_reg == FETCH) begin
                if (bus.if_req) begin
                    if_valid_reg <= 1'b1;
                    if (if_bad) begin
                        if_fault_reg  <= 1'b1;
                        if_instr_reg  <= NOP;
                        fault_cnt_reg <= sat_inc(fault_cnt_reg);
                    end else begin
                        if_instr_reg  <= bus.mem_inst_out;
                        fetch_cnt_reg <= sat_inc(fetch_cnt_reg);
                    end
                end
            end else if (bus.dm_req) begin
                dm_done_reg <= 1'b1;
                if (dm_bad) begin
                    dm_fault_reg  <= 1'b1;
                    dm_rdata_reg  <= '0;
                    fault_cnt_reg <= sat_inc(fault_cnt_reg);
                end else if (bus.dm_we) begin
                    dm_rdata_reg  <= '0;
                    store_cnt_reg <= sat_inc(store_cnt_reg);
                end else begin
                    dm_rdata_reg <= bus.mem_data_out;
                    load_cnt_reg <= sat_inc(load_cnt_reg);
                end
            end
        end
    end

    assign bus.if_valid  = if_valid_reg;
    assign bus.if_fault  = if_fault_reg;
    assign bus.if_instr  = if_instr_reg;
    assign bus.if_stall  = bus.if_req && (phase_reg == DATA);
    assign bus.dm_done   = dm_done_reg;
    assign bus.dm_fault  = dm_fault_reg;
    assign bus.dm_rdata  = dm_rdata_reg;
    assign bus.dm_stall  = bus.dm_req && (phase_reg == FETCH);
    assign bus.fetch_cnt = fetch_cnt_reg;
    assign bus.load_cnt  = load_cnt_reg;
    assign bus.store_cnt = store_cnt_reg;
    assign bus.fault_cnt = fault_cnt_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl with a small behavioural memory:
// byte-wide data store written on MemWrite, sign/zero-extending load port,
// and a two-entry instruction table. One line per failed comparison and a
// final summary line.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl_if #(.ADDR_W(9), .CNT_W(16)) bus ();

    mem_access_ctrl #(.ADDR_W(9), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory model.
    logic [7:0] dmem [0:511];
    logic [8:0] ma0, ma1, ma2, ma3;
    assign ma0 = bus.mem_addr;
    assign ma1 = bus.mem_addr + 9'd1;
    assign ma2 = bus.mem_addr + 9'd2;
    assign ma3 = bus.mem_addr + 9'd3;

    always_ff @(posedge clk) begin
        if (bus.mem_write) begin
            dmem[ma0] <= bus.mem_wdata[7:0];
            if (bus.mem_funct3[1:0] != 2'b00) dmem[ma1] <= bus.mem_wdata[15:8];
            if (bus.mem_funct3[1:0] == 2'b10) begin
                dmem[ma2] <= bus.mem_wdata[23:16];
                dmem[ma3] <= bus.mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        bus.mem_data_out = 32'h0;
        case (bus.mem_funct3)
            3'b000:  bus.mem_data_out = {{24{dmem[ma0][7]}}, dmem[ma0]};
            3'b001:  bus.mem_data_out = {{16{dmem[ma1][7]}}, dmem[ma1], dmem[ma0]};
            3'b010:  bus.mem_data_out = {dmem[ma3], dmem[ma2], dmem[ma1], dmem[ma0]};
            3'b100:  bus.mem_data_out = {24'h0, dmem[ma0]};
            3'b101:  bus.mem_data_out = {16'h0, dmem[ma1], dmem[ma0]};
            default: bus.mem_data_out = 32'h0;
        endcase
    end

    assign bus.mem_inst_out = (bus.mem_addr == 9'd4) ? 32'h0190_0093 :
                              (bus.mem_addr == 9'd8) ? 32'h0020_8133 : 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_dm(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
        bus.dm_req    = req;
        bus.dm_we     = we;
        bus.dm_addr   = addr;
        bus.dm_wdata  = wdata;
        bus.dm_funct3 = f3;
    endtask

    initial begin
        bus.if_req = 1'b0;
        bus.if_pc  = 32'h0;
        set_dm(1'b0, 1'b0, 32'h0, 32'h0, 3'b000);

        // Release reset between edges; phase is FETCH.
        #12;
        rst = 1'b0;
        bus.if_req = 1'b1;
        bus.if_pc  = 32'd4;
        #1;
        chk("rst_if_instr", bus.if_instr, 32'h0000_0033);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_dm_done", 32'(bus.dm_done), 32'd0);
        chk("rst_dm_rdata", bus.dm_rdata, 32'd0);
        chk("rst_fetch_cnt", 32'(bus.fetch_cnt), 32'd0);
        chk("rst_fault_cnt", 32'(bus.fault_cnt), 32'd0);
        chk("fetch_phase_slow", 32'(bus.mem_clk_slow), 32'd1);
        chk("fetch_no_stall", 32'(bus.if_stall), 32'd0);
        chk("fetch_mem_addr", 32'(bus.mem_addr), 32'd4);
        chk("fetch_no_read", 32'(bus.mem_read), 32'd0);

        tick(); // DATA
        chk("fetch_valid", 32'(bus.if_valid), 32'd1);
        chk("fetch_instr", bus.if_instr, 32'h0190_0093);
        chk("fetch_cnt1", 32'(bus.fetch_cnt), 32'd1);
        chk("fetch_nofault", 32'(bus.if_fault), 32'd0);
        chk("data_phase_slow", 32'(bus.mem_clk_slow), 32'd0);
        bus.if_req = 1'b0;

        tick(); // FETCH
        chk("fetch_valid_clear", 32'(bus.if_valid), 32'd0);
        set_dm(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010); // SW
        #1;
        chk("sw_stall", 32'(bus.dm_stall), 32'd1);
        chk("sw_no_write_fetch", 32'(bus.mem_write), 32'd0);

        tick(); // DATA
        chk("sw_stall_clear", 32'(bus.dm_stall), 32'd0);
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        chk("sw_mem_addr", 32'(bus.mem_addr), 32'h100);
        chk("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("sw_not_done_yet", 32'(bus.dm_done), 32'd0);

        tick(); // FETCH
        chk("sw_done", 32'(bus.dm_done), 32'd1);
        chk("sw_nofault", 32'(bus.dm_fault), 32'd0);
        chk("sw_store_cnt", 32'(bus.store_cnt), 32'd1);
        chk("sw_write_clear", 32'(bus.mem_write), 32'd0);
        set_dm(1'b1, 1'b0, 32'h100, 32'h0, 3'b010); // LW

        tick(); // DATA
        chk("lw_mem_read", 32'(bus.mem_read), 32'd1);
        tick(); // FETCH
        chk("lw_done", 32'(bus.dm_done), 32'd1);
        chk("lw_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        chk("lw_load_cnt", 32'(bus.load_cnt), 32'd1);
        bus.dm_funct3 = 3'b000; // LB

        tick(); tick();
        chk("lb_rdata", bus.dm_rdata, 32'hFFFF_FFEF);
        bus.dm_funct3 = 3'b100; // LBU

        tick(); tick();
        chk("lbu_rdata", bus.dm_rdata, 32'h0000_00EF);
        chk("lbu_load_cnt", 32'(bus.load_cnt), 32'd3);
        set_dm(1'b1, 1'b0, 32'h102, 32'h0, 3'b010); // misaligned LW

        tick(); // DATA
        chk("lw_mis_no_read", 32'(bus.mem_read), 32'd0);
        tick(); // FETCH
        chk("lw_mis_done", 32'(bus.dm_done), 32'd1);
        chk("lw_mis_fault", 32'(bus.dm_fault), 32'd1);
        chk("lw_mis_rdata", bus.dm_rdata, 32'd0);
        chk("lw_mis_fault_cnt", 32'(bus.fault_cnt), 32'd1);
        chk("lw_mis_load_cnt", 32'(bus.load_cnt), 32'd3);
        set_dm(1'b1, 1'b1, 32'h101, 32'hDEAD_BEEF, 3'b001); // misaligned SH

        tick(); // DATA
        chk("sh_mis_no_write", 32'(bus.mem_write), 32'd0);
        tick(); // FETCH
        chk("sh_mis_done", 32'(bus.dm_done), 32'd1);
        chk("sh_mis_fault", 32'(bus.dm_fault), 32'd1);
        chk("sh_mis_fault_cnt", 32'(bus.fault_cnt), 32'd2);
        chk("sh_mis_store_cnt", 32'(bus.store_cnt), 32'd1);
        set_dm(1'b1, 1'b0, 32'h100, 32'h0, 3'b010); // LW, memory untouched

        tick(); tick();
        chk("lw_after_sh", bus.dm_rdata, 32'hDEAD_BEEF);
        chk("lw_after_sh_cnt", 32'(bus.load_cnt), 32'd4);

        // Simultaneous requests, raised in FETCH, LW still held.
        bus.if_req = 1'b1;
        bus.if_pc  = 32'd8;
        #1;
        chk("both_if_stall", 32'(bus.if_stall), 32'd0);
        chk("both_dm_stall", 32'(bus.dm_stall), 32'd1);
        tick(); // DATA
        chk("both_if_valid", 32'(bus.if_valid), 32'd1);
        chk("both_if_instr", bus.if_instr, 32'h0020_8133);
        chk("both_dm_not_yet", 32'(bus.dm_done), 32'd0);
        chk("both_fetch_cnt", 32'(bus.fetch_cnt), 32'd2);
        bus.if_req = 1'b0;
        tick(); // FETCH
        chk("both_dm_done", 32'(bus.dm_done), 32'd1);
        chk("both_if_valid_clr", 32'(bus.if_valid), 32'd0);
        chk("both_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        bus.dm_req = 1'b0;

        // Fetch faults: misaligned pc, then held back-to-back with pc out of range.
        bus.if_req = 1'b1;
        bus.if_pc  = 32'd6;
        tick(); // DATA
        chk("if_mis_valid", 32'(bus.if_valid), 32'd1);
        chk("if_mis_fault", 32'(bus.if_fault), 32'd1);
        chk("if_mis_instr", bus.if_instr, 32'h0000_0033);
        chk("if_mis_fault_cnt", 32'(bus.fault_cnt), 32'd3);
        bus.if_pc = 32'h200;
        tick(); // FETCH
        chk("if_valid_gap", 32'(bus.if_valid), 32'd0);
        tick(); // DATA
        chk("if_range_fault", 32'(bus.if_fault), 32'd1);
        chk("if_range_cnt", 32'(bus.fault_cnt), 32'd4);
        chk("if_range_fetch_cnt", 32'(bus.fetch_cnt), 32'd2);
        bus.if_req = 1'b0;

        tick(); // FETCH
        set_dm(1'b1, 1'b1, 32'h100, 32'h1234_5678, 3'b100); // illegal store funct3
        tick(); // DATA
        chk("st_f3_no_write", 32'(bus.mem_write), 32'd0);
        tick(); // FETCH
        chk("st_f3_fault", 32'(bus.dm_fault), 32'd1);
        chk("st_f3_fault_cnt", 32'(bus.fault_cnt), 32'd5);
        set_dm(1'b1, 1'b0, 32'h1FC, 32'h0, 3'b010); // last legal word
        tick(); // DATA
        chk("lw_top_read", 32'(bus.mem_read), 32'd1);
        tick(); // FETCH
        chk("lw_top_nofault", 32'(bus.dm_fault), 32'd0);
        chk("lw_top_load_cnt", 32'(bus.load_cnt), 32'd6);
        bus.dm_addr = 32'h200;
        tick(); // DATA
        chk("lw_oor_no_read", 32'(bus.mem_read), 32'd0);
        tick(); // FETCH
        chk("lw_oor_fault", 32'(bus.dm_fault), 32'd1);
        chk("lw_oor_fault_cnt", 32'(bus.fault_cnt), 32'd6);

        // Reset during a DATA phase with a pending load.
        bus.dm_addr = 32'h100;
        tick(); // DATA, load pending
        rst = 1'b1;
        #1;
        chk("rst_mid_phase", 32'(bus.mem_clk_slow), 32'd1);
        chk("rst_mid_load_cnt", 32'(bus.load_cnt), 32'd0);
        tick();
        bus.dm_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_no_done", 32'(bus.dm_done), 32'd0);
        chk("rst_mid_fetch_cnt", 32'(bus.fetch_cnt), 32'd0);
        chk("rst_mid_store_cnt", 32'(bus.store_cnt), 32'd0);
        chk("rst_mid_fault_cnt", 32'(bus.fault_cnt), 32'd0);
        chk("rst_mid_rdata", bus.dm_rdata, 32'd0);
        tick();
        chk("rst_after_no_done", 32'(bus.dm_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator for the shared 512-byte unified instruction/data memory.
- Time-multiplexes the single memory port between instruction fetch and load/store:
  - drives the memory's clk_slow phase signal, address, MemRead/MemWrite, funct3 and store data;
  - registers returned instruction/load data back to the pipeline with one-cycle valid pulses.
- Also checks alignment/funct3 legality and keeps access counters.

Parameters:
- ADDR_W, 9, memory byte-address width (512 bytes).
- CNT_W, 16, width of each saturating access counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request, held until if_valid.
- if_pc  in  32  fetch byte address; bits [ADDR_W-1:0] used.
- if_valid  out  1  one-cycle pulse: if_instr valid.
- if_instr  out  32  fetched instruction.
- if_fault  out  1  with if_valid: pc misaligned or out of range.
- if_stall  out  1  combinational: if_req high while phase is DATA.
- dm_req  in  1  load/store request, held until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_funct3  in  3  RV32I load/store funct3.
- dm_done  out  1  one-cycle pulse: access complete.
- dm_rdata  out  32  load result, already sign/zero-extended by memory.
- dm_fault  out  1  with dm_done: misaligned, out of range, or illegal funct3.
- dm_stall  out  1  combinational: dm_req high while phase is FETCH.
- mem_clk_slow  out  1  memory fetch phase select.
- mem_read  out  1  memory MemRead.
- mem_write  out  1  memory MemWrite.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  32  memory data_in.
- mem_funct3  out  3  memory funct3.
- mem_inst_out  in  32  memory instruction output.
- mem_data_out  in  32  memory load output.
- fetch_cnt, load_cnt, store_cnt, fault_cnt  out  CNT_W each  saturating counters.

Behaviour:
- Clock and reset:
  - One clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - phase = FETCH.
  - if_valid, if_fault, dm_done, dm_fault = 0.
  - if_instr = 32'h00000033 (NOP).
  - dm_rdata = 0.
  - All counters = 0.
  - Reset mid-access aborts it; no pulse is produced.
- Phase register:
  - Toggles FETCH->DATA->FETCH every cycle, regardless of requests.
- FETCH phase (combinational outputs):
  - mem_clk_slow=1, mem_addr=if_pc[ADDR_W-1:0].
  - mem_read=0, mem_write=0, mem_wdata=0, mem_funct3=0.
- FETCH phase (at the clock edge, if if_req):
  - Legal access: if_instr<=mem_inst_out, if_valid<=1, fetch_cnt++.
  - Faulting access: if_pc[1:0]!=0 or if_pc>=2^ADDR_W-3. Then if_instr<=NOP, if_valid<=1, if_fault<=1, fault_cnt++.
- DATA phase, no request or fault:
  - mem_clk_slow=0; mem_addr=dm_addr[ADDR_W-1:0] (mem_funct3=dm_funct3, mem_wdata=dm_wdata).
  - Strobes mem_read/mem_write stay 0 when dm_req=0 or when the access faults.
- DATA phase, legal request:
  - Load: mem_read=1. Store: mem_write=1 (memory writes at this edge).
- DATA phase completion at the edge (if dm_req):
  - dm_done<=1.
  - Load: dm_rdata<=mem_data_out, load_cnt++.
  - Store: dm_rdata<=0, store_cnt++.
- Fault conditions (dm_fault<=1, dm_rdata<=0, fault_cnt++, no memory strobe):
  - Load funct3 not in {000,001,010,100,101}.
  - Store funct3 not in {000,001,010}.
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
  - Last accessed byte address >= 2^ADDR_W.
- Pulse outputs (if_valid, if_fault, dm_done, dm_fault) are high for exactly one cycle, then clear.
- Latency:
  - 1 cycle if the request arrives in its own phase; 2 cycles otherwise (stall asserted for the first).
- Simultaneous if_req and dm_req:
  - Both are served in consecutive cycles; no starvation.
  - Worst case is 2 cycles per request.
- Counters saturate at all-ones and never wrap.
- Requester obligations:
  - Hold inputs stable while req is high.
  - Deassert req the cycle after the done/valid pulse, or keep it high to issue a back-to-back access two cycles later.

Test Plan:
- Reset then if_req with if_pc=4, held: if_stall=0 in the first FETCH cycle; next cycle if_valid=1, if_instr=32'h01900093, fetch_cnt=1.
- Store SW: dm_addr=0x100, dm_wdata=0xDEADBEEF, funct3=010, raised in FETCH phase.
  - Required: dm_stall=1 for one cycle, then mem_write=1 for one cycle, dm_done=1, store_cnt=1.
  - Follow-up LW at 0x100 returns dm_rdata=0xDEADBEEF.
- LB at 0x100 returns 0xFFFFFFEF; LBU at 0x100 returns 0x000000EF; load_cnt increments by 2.
- Misaligned accesses:
  - LW at 0x102 -> dm_done=1, dm_fault=1, mem_read never high, dm_rdata=0, fault_cnt=1.
  - SH at 0x101 -> same, mem_write never high.
- if_req and dm_req asserted together, held: exactly one if_valid and one dm_done within 2 cycles, in phase order.
- Assert rst during a DATA phase with dm_req=1: no dm_done; phase=FETCH and all counters 0 after release.
